dpram_burst_reader: RTL and testbench

Read-side engine for the 16x8 dual-port RAM: accepts a burst request (start address, beat count), drives one RAM port's address with the RAM's one-cycle registered-read latency, and presents the returned words as a valid/ready stream with last-beat marking. It sits between a RAM read port and a downstream consumer. An internal 4-entry output buffer and read-credit logic let it run at one word per cycle under backpressure with no lost or duplicated beats.

---
 rtl/dpram_burst_reader.sv | 108 ++++++++++
 tb/tb_dpram_burst_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dpram_burst_reader.sv
// Burst read engine for a 16x8 dual-port RAM with a 1-cycle registered read, credit-limited 4-entry output buffer.
// Optional: define DPRAM_RD_WRAP_EN to let bursts wrap past the top address instead of truncating.
module dpram_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
);
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                       state_q;
  logic                         busy_q;
  logic [ADDR_W-1:0]            ram_addr_q;
  logic [ADDR_W:0]              rem_q, req_beats;
  logic [1:0]                   vld_pipe_q, last_pipe_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             lastb_q;
  logic [PW-1:0]                wr_q, rd_q;
  logic [PW:0]                  occ_q, pend;
  logic                         accept, credit_ok, issue_nxt, issue_now, issue_last, pop;

`ifdef DPRAM_RD_WRAP_EN
  assign req_beats = {1'b0, req_len} + (ADDR_W+1)'(1);
`else
  logic [ADDR_W-1:0] room;
  assign room      = ~req_addr;
  assign req_beats = {1'b0, (req_len > room) ? room : req_len} + (ADDR_W+1)'(1);
`endif

  // vld_pipe_q[0]: read on ram_addr this cycle; [1]: its data is on ram_dout this cycle
  assign pend       = occ_q + {{PW{1'b0}}, vld_pipe_q[0]} + {{PW{1'b0}}, vld_pipe_q[1]};
  assign credit_ok  = pend < (PW+1)'(DEPTH);
  assign accept     = req_valid && req_ready;
  assign issue_nxt  = (state_q == ISSUE) && (rem_q != '0) && credit_ok;
  assign issue_now  = accept || issue_nxt;
  assign issue_last = accept ? (req_beats == (ADDR_W+1)'(1)) : (rem_q == (ADDR_W+1)'(1));
  assign pop        = m_valid && m_ready;

  assign req_ready = rst_n && (state_q == IDLE);
  assign m_valid   = (occ_q != '0);
  assign m_data    = data_q[rd_q];
  assign m_last    = m_valid && lastb_q[rd_q];
  assign ram_addr  = ram_addr_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      ram_addr_q  <= '0;
      rem_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      data_q      <= '0;
      lastb_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      occ_q       <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[0], issue_now};
      last_pipe_q <= {last_pipe_q[0], issue_now && issue_last};

      if (accept) begin
        ram_addr_q <= req_addr;
        rem_q      <= req_beats - (ADDR_W+1)'(1);
      end else if (issue_nxt) begin
        ram_addr_q <= ram_addr_q + ADDR_W'(1);
        rem_q      <= rem_q - (ADDR_W+1)'(1);
      end

      if (vld_pipe_q[1]) begin
        data_q[wr_q]  <= ram_dout;
        lastb_q[wr_q] <= last_pipe_q[1];
        wr_q          <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      occ_q <= occ_q + {{PW{1'b0}}, vld_pipe_q[1]} - {{PW{1'b0}}, pop};

      case (state_q)
        IDLE: if (accept) begin
          state_q <= ISSUE;
          busy_q  <= 1'b1;
        end
        ISSUE: if (vld_pipe_q[0] && last_pipe_q[0]) state_q <= DRAIN;
        DRAIN: if (pop && m_last) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dpram_burst_reader.sv
// Self-checking bench: behavioural RAM, directed scenarios plus random bursts scored against a beat-list model.
module tb_dpram_burst_reader;
  logic       clk, rst_n, req_valid, req_ready, m_valid, m_ready, m_last, busy;
  logic [3:0] req_addr, req_len, ram_addr;
  logic [7:0] ram_dout, m_data;
  logic [7:0] mem [16];

  int errs, checks, cyc, pat_i, rmode, acc_cyc;
  bit acc_seen, prev_stall, hold_l;
  logic [7:0] hold_d;
  logic [3:0] pat;
  logic [8:0] exp_q [$];
  int         hs_q [$];

  dpram_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A burst delivers consecutive words; without wrap it stops at the top address.
  function automatic void push_exp(input logic [3:0] a, input logic [3:0] l);
    int n;
`ifdef DPRAM_RD_WRAP_EN
    n = int'(l) + 1;
`else
    n = (int'(l) > 15 - int'(a)) ? 16 - int'(a) : int'(l) + 1;
`endif
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), mem[(int'(a) + i) % 16]});
  endfunction

  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    acc_seen = req_valid && req_ready;
    if (prev_stall) begin
      chk("hold_vld", 32'(m_valid), 1);
      chk("hold_data", 32'(m_data), 32'(hold_d));
      chk("hold_last", 32'(m_last), 32'(hold_l));
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(m_data), 32'(e[7:0]));
        chk("beat_last", 32'(m_last), 32'(e[8]));
      end
      hs_q.push_back(cyc);
    end
    prev_stall = m_valid && !m_ready;
    hold_d = m_data;
    hold_l = m_last;
    if (acc_seen) begin
      acc_cyc = cyc;
      push_exp(req_addr, req_len);
    end
    @(posedge clk);
    cyc++;
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = pat[pat_i % 4];
      default: m_ready = ($urandom_range(0, 9) < 7);
    endcase
    pat_i++;
  endtask

  task automatic burst(input logic [3:0] a, input logic [3:0] l, input bit hold, output int k);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    for (int i = 0; i < 200; i++) begin
      step();
      if (acc_seen) break;
    end
    chk("accepted", 32'(acc_seen), 1);
    k = acc_cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      step();
    end
    chk("drained", 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    int k, k2, base, n;
    errs = 0; checks = 0; cyc = 0; pat_i = 0; rmode = 0;
    pat = 4'b1001;
    prev_stall = 0; hold_d = '0; hold_l = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; m_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_req_ready", 32'(req_ready), 1);
    @(posedge clk);
    #1 m_ready = 1'b1;

    // addr 2 len 3, ready high: beats on k+3..k+6
    base = hs_q.size();
    burst(4'd2, 4'd3, 0, k);
    wait_idle();
    chk("t1_cnt", 32'(hs_q.size() - base), 4);
    for (int i = 0; i < 4 && base + i < hs_q.size(); i++)
      chk("t1_cyc", 32'(hs_q[base + i]), 32'(k + 3 + i));

    // full burst, ready high: last handshake at k+18
    base = hs_q.size();
    burst(4'd0, 4'd15, 0, k);
    wait_idle();
    chk("t2a_cnt", 32'(hs_q.size() - base), 16);
    if (hs_q.size() > 0) chk("t2a_last_cyc", 32'(hs_q[hs_q.size() - 1]), 32'(k + 18));

    // full burst with 1,0,0,1 backpressure
    rmode = 1; pat_i = 0;
    base = hs_q.size();
    burst(4'd0, 4'd15, 0, k);
    wait_idle();
    chk("t2b_cnt", 32'(hs_q.size() - base), 16);
    rmode = 0;

    // top-of-memory burst
    base = hs_q.size();
    burst(4'd14, 4'd3, 0, k);
    wait_idle();
`ifdef DPRAM_RD_WRAP_EN
    n = 4;
`else
    n = 2;
`endif
    chk("t3_cnt", 32'(hs_q.size() - base), 32'(n));

    // req_valid held across two bursts
    base = hs_q.size();
    burst(4'd0, 4'd0, 1, k);
    burst(4'd5, 4'd1, 0, k2);
    wait_idle();
    chk("t4_cnt", 32'(hs_q.size() - base), 3);
    if (hs_q.size() > base) chk("t4_turnaround", 32'(k2), 32'(hs_q[base] + 1));

    // reset during the 3rd beat of a 16-beat burst
    base = hs_q.size();
    burst(4'd0, 4'd15, 0, k);
    for (int i = 0; i < 20 && hs_q.size() - base < 2; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_m_valid", 32'(m_valid), 0);
    chk("mid_m_data", 32'(m_data), 0);
    chk("mid_m_last", 32'(m_last), 0);
    chk("mid_ram_addr", 32'(ram_addr), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_req_ready", 32'(req_ready), 0);
    exp_q.delete();
    prev_stall = 0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("mid_rel_ready", 32'(req_ready), 1);
    repeat (10) step();
    chk("mid_quiet_busy", 32'(busy), 0);

    // random bursts, random data and random backpressure
    rmode = 2;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      burst(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, k);
      wait_idle();
    end
    rmode = 0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
